// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment type, blank code and hex glyph table shared by the scan driver
package seven_seg_pkg;
   typedef logic [6:0] seg_t;
   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   // a 4-bit nibble always lands inside the table, so no blank fallback is reachable
   function automatic seg_t hex_to_seg(input logic [3:0] h);
      return GLYPH[h];
   endfunction
endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: datapath-side controls and board-side display pins of the scan driver
interface seven_seg_scan_if import seven_seg_pkg::*; #(parameter int NUM_DIGITS = 4);
   logic                    enable;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   seg_t                    seg_n;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    pending;
   logic                    frame_tick;
   modport master (output enable, load, value, dp_in, input seg_n, dp_n, an_n, pending, frame_tick);
   modport slave (input enable, load, value, dp_in, output seg_n, dp_n, an_n, pending, frame_tick);
endinterface

// File: rtl/seven_seg_scan_timer.sv
// seven_seg_scan_timer: slot prescaler, digit index, guard flag and frame-boundary strobe
module seven_seg_scan_timer #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 16,
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int PW = $clog2(REFRESH_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [IW-1:0] o_idx,
   output logic          o_guard,
   output logic          o_wrap
);
   logic [PW-1:0] r_presc;
   logic [IW-1:0] r_idx;
   logic          w_tc;
   assign w_tc    = r_presc == PW'(REFRESH_DIV - 1);
   assign o_wrap  = w_tc && (r_idx == IW'(NUM_DIGITS - 1));
   assign o_guard = r_presc < PW'(GUARD_CYCLES);
   assign o_idx   = r_idx;
   // prescaler times each slot; the index steps at terminal count and wraps after the last digit
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         r_presc <= w_tc ? '0 : r_presc + 1'b1;
         if (w_tc) r_idx <= o_wrap ? '0 : r_idx + 1'b1;
      end
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: tear-free multiplexed seven-segment driver; SEVSEG_LZB_EN adds leading-zero blanking
module seven_seg_scan import seven_seg_pkg::*; #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 16
) (
   input logic             clk,
   input logic             rst_n,
   seven_seg_scan_if.slave bus
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   logic [IW-1:0]           w_idx;
   logic                    w_guard, w_wrap, w_commit;
   logic [4*NUM_DIGITS-1:0] r_shadow, r_disp, w_val;
   logic [NUM_DIGITS-1:0]   r_shadow_dp, r_disp_dp, w_dp, w_blank;
   logic                    r_pending, r_dp_n, r_tick;
   logic [NUM_DIGITS-1:0]   r_an_n;
   seg_t                    r_seg;
   seven_seg_scan_timer #(
      .NUM_DIGITS(NUM_DIGITS), .REFRESH_DIV(REFRESH_DIV), .GUARD_CYCLES(GUARD_CYCLES)
   ) u_timer (
      .clk(clk), .rst_n(rst_n), .o_idx(w_idx), .o_guard(w_guard), .o_wrap(w_wrap)
   );
   assign w_val    = bus.load ? bus.value : r_shadow;
   assign w_dp     = bus.load ? bus.dp_in : r_shadow_dp;
   assign w_commit = w_wrap && (bus.load || r_pending);
`ifdef SEVSEG_LZB_EN
   logic [NUM_DIGITS-1:0] w_mask, r_blank;
   logic                  w_z;
   // a digit blanks when it and every more significant nibble are zero; digit 0 always shows
   always_comb begin
      w_mask = '0;
      w_z    = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         w_z       = w_z && (w_val[4*i +: 4] == 4'h0);
         w_mask[i] = w_z;
      end
   end
   // mask travels with the display word so both switch on the same boundary; reset matches word 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_blank <= ~NUM_DIGITS'(1);
      else if (w_commit) r_blank <= w_mask;
   assign w_blank = r_blank;
`else
   assign w_blank = '0;
`endif
   // shadow captures loads; display takes the newest value only at a frame boundary
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_disp      <= '0;
         r_disp_dp   <= '0;
         r_pending   <= 1'b0;
      end else begin
         if (bus.load) begin
            r_shadow    <= bus.value;
            r_shadow_dp <= bus.dp_in;
         end
         if (w_commit) begin
            r_disp    <= w_val;
            r_disp_dp <= w_dp;
         end
         r_pending <= (bus.load || r_pending) && !w_wrap;
      end
   // pin drivers lag the scan state by one cycle; anodes stay dark in guard or when disabled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_seg  <= SEG_BLANK;
         r_dp_n <= 1'b1;
         r_an_n <= '1;
         r_tick <= 1'b0;
      end else begin
         r_seg  <= w_blank[w_idx] ? SEG_BLANK : hex_to_seg(r_disp[{w_idx, 2'b00} +: 4]);
         r_dp_n <= ~r_disp_dp[w_idx];
         r_an_n <= (bus.enable && !w_guard) ? ~(NUM_DIGITS'(1) << w_idx) : '1;
         r_tick <= w_wrap;
      end
   assign bus.seg_n      = r_seg;
   assign bus.dp_n       = r_dp_n;
   assign bus.an_n       = r_an_n;
   assign bus.pending    = r_pending;
   assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed checks of slot timing, tear-free commit, enable gating, reset and blanking
module tb_seven_seg_scan;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   k = 0;
   int   total = 0;
   int   bad = 0;
   seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();
   seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   // clock edges since reset release; outputs at edge k reflect scan state k-1
   always @(posedge clk or negedge rst_n)
      if (!rst_n) k <= 0;
      else k <= k + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      bus.value = v;
      bus.dp_in = d;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
   endtask
   task automatic frame_start();
      int n = 0;
      while ((k - 1) % 32 != 0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) check("frame_align", n, 0);
   endtask
   task automatic scan(input string tag, input logic [27:0] segs, input logic [3:0] dpn);
      logic [3:0] e;
      frame_start();
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s_guard%0d", tag, d), bus.an_n, 4'hF);
         repeat (4) @(negedge clk);
         e = ~(4'b0001 << d);
         check($sformatf("%s_an%0d", tag, d), bus.an_n, e);
         check($sformatf("%s_seg%0d", tag, d), bus.seg_n, segs[d*7 +: 7]);
         check($sformatf("%s_dp%0d", tag, d), bus.dp_n, dpn[d]);
         repeat (4) @(negedge clk);
      end
   endtask
   initial begin
      logic [3:0]  e;
      logic [27:0] zs, l70, l00;
      int          n;
`ifdef SEVSEG_LZB_EN
      zs  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
      l70 = {7'h7F, 7'h7F, 7'h78, 7'h40};
      l00 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
      zs  = {7'h40, 7'h40, 7'h40, 7'h40};
      l70 = {7'h40, 7'h40, 7'h78, 7'h40};
      l00 = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
      bus.enable = 1'b1;
      bus.load   = 1'b0;
      bus.value  = '0;
      bus.dp_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_seg", bus.seg_n, 7'h7F);
      check("rst_an", bus.an_n, 4'hF);
      check("rst_dp", bus.dp_n, 1'b1);
      check("rst_pend", bus.pending, 1'b0);
      check("rst_tick", bus.frame_tick, 1'b0);
      rst_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         e = (((i - 1) % 8) >= 1) ? ~(4'b0001 << (((i - 1) / 8) % 4)) : 4'hF;
         check($sformatf("slot_an_%0d", i), bus.an_n, e);
         check($sformatf("slot_tick_%0d", i), bus.frame_tick, i == 32);
      end
      scan("zero", zs, 4'hF);
      repeat (10) @(negedge clk);
      pulse_load(16'h12AF, 4'b0100);
      check("pend_set", bus.pending, 1'b1);
      n = 0;
      while (bus.frame_tick !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tick_seen", bus.frame_tick, 1'b1);
      check("hold_old", bus.seg_n, zs[27:21]);
      check("pend_clr", bus.pending, 1'b0);
      scan("v12af", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);
      repeat (3) @(negedge clk);
      pulse_load(16'h1111, 4'b0001);
      repeat (4) @(negedge clk);
      pulse_load(16'h2222, 4'b0000);
      check("pend_two", bus.pending, 1'b1);
      scan("last_wins", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
      n = 0;
      while (k % 32 != 31 && n < 64) begin
         @(negedge clk);
         n++;
      end
      pulse_load(16'h3456, 4'b1000);
      check("coinc_tick", bus.frame_tick, 1'b1);
      check("coinc_pend", bus.pending, 1'b0);
      scan("coinc", {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0111);
      bus.enable = 1'b0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         check($sformatf("dis_an_%0d", i), bus.an_n, 4'hF);
         check($sformatf("dis_tick_%0d", i), bus.frame_tick, k % 32 == 0);
      end
      bus.enable = 1'b1;
      scan("reen", {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0111);
      pulse_load(16'h0070, 4'b1000);
      scan("v0070", l70, 4'b0111);
      pulse_load(16'h0000, 4'b0000);
      scan("v0000", l00, 4'hF);
      repeat (5) @(negedge clk);
      pulse_load(16'h9999, 4'hF);
      check("mid_pend", bus.pending, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_pend", bus.pending, 1'b0);
      check("mid_rst_seg", bus.seg_n, 7'h7F);
      check("mid_rst_an", bus.an_n, 4'hF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      scan("post_rst", zs, 4'hF);
      check("post_rst_pend", bus.pending, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
